// File: rtl/fir_mac_serial.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_serial
// Purpose  : Parametrised, multi-channel, time-multiplexed FIR filter. A single
//            shared multiply-accumulate unit walks the TAPS coefficients once
//            per accepted sample. Each channel owns a circular delay line.
//            Coefficients are programmable at run time.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W    sample / output width (signed)
//   COEF_W    coefficient width (signed)
//   TAPS      filter length (>= 2)
//   NUM_CH    number of independent channels
//   OUT_SHIFT arithmetic right shift applied to the accumulator on output
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   sample     in   one-cycle strobe, xIn/ch valid
//   ch         in   channel of incoming sample
//   xIn        in   input sample
//   coef_we    in   coefficient write enable (ignored while busy)
//   coef_addr  in   coefficient index k (h[k])
//   coef_data  in   coefficient value
//   busy       out  MAC in progress
//   yValid     out  one-cycle strobe, yOut/yCh valid
//   yCh        out  channel of yOut
//   yOut       out  filtered output (held until next yValid)
//   overrun    out  sticky: a sample was dropped (busy or bad channel)
//   sat        out  (FIR_SAT_EN only) pulses with yValid when clipping occurred
// Build option
//   FIR_SAT_EN  round half up before the shift and saturate to DATA_W;
//               otherwise the shifted accumulator is truncated (wraps).
// ============================================================================
module fir_mac_serial #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int NUM_CH    = 1,
  parameter int OUT_SHIFT = 15,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W   = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample,
  input  logic [CH_W-1:0]   ch,
  input  logic [DATA_W-1:0] xIn,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              busy,
  output logic              yValid,
  output logic [CH_W-1:0]   yCh,
  output logic [DATA_W-1:0] yOut,
`ifdef FIR_SAT_EN
  output logic              sat,
`endif
  output logic              overrun
);

  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS);
  // Storage is sized to the full channel-index range so any ch value indexes
  // a real row; rows beyond NUM_CH are never written and stay constant zero.
  localparam int CH_SLOTS = 1 << CH_W;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [CH_W:0]     NUM_CH_X = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          tap_q, tap_d;   // coefficient index k
  logic [ADDR_W-1:0]          rd_q, rd_d;     // delay-line slot holding x[n-k]
  logic [CH_W-1:0]            mch_q, mch_d;   // channel being filtered
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       yValid_q, yValid_d;
  logic [CH_W-1:0]            yCh_q, yCh_d;
  logic [DATA_W-1:0]          yOut_q, yOut_d;
  logic                       overrun_q, overrun_d;

  logic [DATA_W-1:0]          dline_q [CH_SLOTS][TAPS];
  logic [ADDR_W-1:0]          wptr_q  [CH_SLOTS];
  logic [COEF_W-1:0]          coef_q  [TAPS];

  logic                       ch_ok;
  logic                       idle_like;
  logic                       accept;
  logic                       coef_wr;
  logic signed [DATA_W-1:0]   x_sel;
  logic signed [COEF_W-1:0]   h_sel;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic [DATA_W-1:0]          y_conv;

  // --------------------------------------------------------------------------
  // Admission control. IDLE and OUT both accept a new sample, which is what
  // gives the TAPS+1 minimum sample spacing.
  // --------------------------------------------------------------------------
  assign ch_ok     = ({1'b0, ch} < NUM_CH_X);
  assign idle_like = (state_q != S_MAC);
  assign accept    = sample && idle_like && ch_ok;
  assign coef_wr   = coef_we && idle_like && (coef_addr <= LAST_TAP);

  // --------------------------------------------------------------------------
  // Datapath: one full-precision product per MAC cycle.
  // --------------------------------------------------------------------------
  assign x_sel   = $signed(dline_q[mch_q][rd_q]);
  assign h_sel   = $signed(coef_q[tap_q]);
  assign prod    = x_sel * h_sel;
  assign acc_sum = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});

  // --------------------------------------------------------------------------
  // Output conversion of the final accumulator value (acc_sum on the last tap).
  // --------------------------------------------------------------------------
`ifdef FIR_SAT_EN
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic                    sat_q, sat_d;
  logic                    clip;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   shifted;

  // One guard bit so adding the rounding constant can never wrap.
  always_comb begin
    rnd_sum = $signed({acc_sum[ACC_W-1], acc_sum}) + RND;
    shifted = rnd_sum >>> OUT_SHIFT;
    clip    = 1'b0;
    if (shifted > SAT_MAX) begin
      y_conv = {1'b0, {(DATA_W - 1){1'b1}}};
      clip   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      y_conv = {1'b1, {(DATA_W - 1){1'b0}}};
      clip   = 1'b1;
    end else begin
      y_conv = DATA_W'(shifted);
    end
  end
`else
  // Truncate to the low DATA_W bits; out-of-range results wrap.
  assign y_conv = DATA_W'(acc_sum >>> OUT_SHIFT);
`endif

  // --------------------------------------------------------------------------
  // FSM next-state and control.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    rd_d      = rd_q;
    mch_d     = mch_q;
    acc_d     = acc_q;
    yValid_d  = 1'b0;
    yCh_d     = yCh_q;
    yOut_d    = yOut_q;
    overrun_d = overrun_q;
`ifdef FIR_SAT_EN
    sat_d     = 1'b0;
`endif

    // Any dropped sample (busy or illegal channel) latches overrun.
    if (sample && (!idle_like || !ch_ok)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_OUT: begin
        if (accept) begin
          state_d = S_MAC;
          tap_d   = '0;
          // Newest sample lands at the current write pointer; start there.
          rd_d    = wptr_q[ch];
          mch_d   = ch;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + 1'b1;
        // Walk backwards in time: x[n-k] sits one slot behind x[n-k+1].
        rd_d  = (rd_q == '0) ? LAST_TAP : rd_q - 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d  = S_OUT;
          yValid_d = 1'b1;
          yCh_d    = mch_q;
          yOut_d   = y_conv;
`ifdef FIR_SAT_EN
          sat_d    = clip;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control / output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tap_q     <= '0;
      rd_q      <= '0;
      mch_q     <= '0;
      acc_q     <= '0;
      yValid_q  <= 1'b0;
      yCh_q     <= '0;
      yOut_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      rd_q      <= rd_d;
      mch_q     <= mch_d;
      acc_q     <= acc_d;
      yValid_q  <= yValid_d;
      yCh_q     <= yCh_d;
      yOut_q    <= yOut_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef FIR_SAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`endif

  // --------------------------------------------------------------------------
  // Delay lines, write pointers and coefficient memory.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH_SLOTS; c++) begin
        wptr_q[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          dline_q[c][t] <= '0;
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= '0;
      end
    end else begin
      if (accept) begin
        dline_q[ch][wptr_q[ch]] <= xIn;
        wptr_q[ch]              <= (wptr_q[ch] == LAST_TAP) ? '0 : wptr_q[ch] + 1'b1;
      end
      if (coef_wr) begin
        coef_q[coef_addr] <= coef_data;
      end
    end
  end

  assign busy    = (state_q == S_MAC);
  assign yValid  = yValid_q;
  assign yCh     = yCh_q;
  assign yOut    = yOut_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire
